hv_abist_seq: RTL and testbench
===============================

# hv_abist_seq

Parametrised, self-sequencing analog BIST engine for the HV die. It runs up to CH_NUM analog self-tests one after another from a single start pulse. For each test it drives a one-hot request to the analog front end and waits a per-channel timeout for the fault/detect response. It records per-channel pass/fail and inserts a settle gap between tests. It sits between the HV register/control logic, which issues start/abort and reads status, and the HV analog fault comparators and ADC.

## Interface
Parameters:
- CH_NUM, 6, number of BIST channels (1..16)
- CNT_W, 12, width of timeout/settle counter
- CH_TMO, {6{12'd80}}, packed CH_NUM*CNT_W per-channel timeout in cycles, channel i at bits [i*CNT_W +: CNT_W]
- SETTLE_CYC, 16, cycles with all requests low between channels (>=1)
- ADC_DW, 10, ADC sample width
- ADC_CH, CH_NUM-1, channel index whose detect is the ADC window check
- ADC_DN_TH, 10'h1F8, ADC window low bound, inclusive
- ADC_UP_TH, 10'h207, ADC window high bound, inclusive

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  start pulse; ignored while o_busy=1
- i_abort  in  1  abort running sequence
- i_ch_en  in  CH_NUM  channel enable mask, latched at accepted start
- i_detect  in  CH_NUM  synchronised analog detect flags, bit i for channel i
- i_adc_data1  in  ADC_DW  ADC sample 1
- i_adc_data2  in  ADC_DW  ADC sample 2
- o_bist_req  out  CH_NUM  one-hot (or zero) test request to analog
- o_busy  out  1  sequence running
- o_done  out  1  one-cycle pulse at normal sequence end
- o_pass  out  CH_NUM  1: channel passed in last run
- o_fail  out  CH_NUM  1: channel timed out in last run
- o_fail_any  out  1  OR of o_fail

## Operation
- FSM states: IDLE, WAIT, SETTLE, DONE.
- IDLE, i_start=1: latch i_ch_en to en_q. Clear o_pass/o_fail. If en_q≠0, select the lowest set channel cur, set o_bist_req[cur]=1, set cnt=0, and go to WAIT. If en_q=0, go to DONE.
- WAIT, per cycle:
  - det[cur]=1: set o_pass[cur], drop req, cnt=0, go to SETTLE.
  - Else, if cnt==CH_TMO[cur]-1 or CH_TMO[cur]==0: set o_fail[cur], drop req, cnt=0, go to SETTLE.
  - Else cnt++.
- SETTLE: cnt++ until cnt==SETTLE_CYC-1. Then select the next enabled channel above cur:
  - If one exists: req it, cnt=0, go to WAIT.
  - If none: go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- i_abort=1 in any non-IDLE state: go to IDLE next edge with req=0. No o_done. o_pass/o_fail keep the results of completed channels; unfinished channels stay 0. Abort beats a simultaneous detect/timeout.
- i_start and i_abort together in IDLE: start is ignored.
- det[i]=i_detect[i], except for the ADC channel when the macro is enabled (see Configuration).
- i_ch_en changes mid-run have no effect.
- Reset values: o_bist_req=0, o_busy=0, o_done=0, o_pass=0, o_fail=0, o_fail_any=0. FSM goes to IDLE, cnt=0.
- Reset mid-run drops the request asynchronously.

## Timing
- Start sampled at edge k: o_busy=1 and o_bist_req valid from edge k+1.
- Detect sampled at edge m in WAIT: o_pass set and req low from edge m+1.
- With timeout T≥1, a channel fails after exactly T WAIT cycles with no detect.
- Request-low gap between channels is exactly SETTLE_CYC cycles.
- o_busy is high from edge k+1 through the DONE cycle inclusive.
- All outputs are registered.
- cnt never wraps: CH_TMO and SETTLE_CYC must each be ≤ 2^CNT_W-1.

## Configuration
- HV_ABIST_ADC_WIN_EN defined: det[ADC_CH] = (ADC_DN_TH ≤ i_adc_data1 ≤ ADC_UP_TH) & (ADC_DN_TH ≤ i_adc_data2 ≤ ADC_UP_TH), unsigned compare. i_detect[ADC_CH] is ignored.
- Macro undefined: det[ADC_CH]=i_detect[ADC_CH]. The ADC ports are unused and no comparators are synthesised.

## Structure
- hv_abist_pkg holds:
  - the state enum (IDLE/WAIT/SETTLE/DONE)
  - a CH_TMO slice helper function
  - default timeout constants derived from CLK_M (1 µs, 4 µs, 70 µs)
- Sub-module hv_abist_pick: combinational "lowest set bit of mask strictly above index" priority encoder, with a found flag and the index. It is used for both first-channel and next-channel selection.

## Test plan
- CH_NUM=6, en=6'b111111, each i_detect asserted 3 cycles after its req → pass=6'h3F, fail=0. Requests go 0→5 in order with 16-cycle gaps, and o_done pulses once.
- en=6'b000101, ch2 detect never asserted, CH_TMO=80 → o_fail=6'b000100 after exactly 80 WAIT cycles, o_pass=6'b000001, o_fail_any=1.
- en=0 start → o_busy high 1 cycle, o_done pulse, pass=fail=0.
- ADC macro on, data1=0x1F8, data2=0x207 → ch5 pass. Rerun with data2=0x208 → ch5 fail.
- i_abort while in WAIT on ch3 (ch0–2 passed) → req=0 next edge, no o_done, o_pass=6'b000111, o_fail=0.
- i_start pulsed while busy and i_rst_n dropped mid-WAIT → start ignored. After reset all outputs are 0 and the FSM is in IDLE.

Source files
------------

// File: rtl/hv_abist_pkg.sv
// Shared types and helpers for the HV analog BIST sequencer.
// Timeout constants assume a 20 MHz control clock (CLK_M cycles per microsecond).
package hv_abist_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_SETTLE,
        S_DONE
    } state_t;

    localparam int unsigned CLK_M     = 20;
    localparam int unsigned TMO_1US   = 1 * CLK_M;
    localparam int unsigned TMO_4US   = 4 * CLK_M;
    localparam int unsigned TMO_70US  = 70 * CLK_M;
    localparam int unsigned TMO_VEC_W = 512;

    // Extracts field idx of width w (w <= 32) from a packed per-channel vector.
    function automatic logic [31:0] tmo_slice(input logic [TMO_VEC_W-1:0] vec,
                                              input int unsigned idx,
                                              input int unsigned w);
        logic [TMO_VEC_W-1:0] shifted;
        logic [31:0]          r;
        shifted = vec >> (idx * w);
        r       = shifted[31:0];
        if (w < 32)
            r = r & ((32'd1 << w) - 32'd1);
        return r;
    endfunction

endpackage

// File: rtl/hv_abist_pick.sv
// Priority encoder: lowest set mask bit strictly above idx, or the lowest set
// bit overall when from_zero is high.
module hv_abist_pick #(
    parameter int N  = 6,
    parameter int IW = 3
) (
    input  logic [N-1:0]  mask,
    input  logic [IW-1:0] idx,
    input  logic          from_zero,
    output logic          found,
    output logic [IW-1:0] sel
);

    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && mask[i] && (from_zero || (i > 32'(idx)))) begin
                found = 1'b1;
                sel   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/hv_abist_seq.sv
// Self-sequencing analog BIST engine: runs enabled channels in ascending order.
// Optional ADC window detect on channel ADC_CH is enabled by HV_ABIST_ADC_WIN_EN.
module hv_abist_seq
    import hv_abist_pkg::*;
#(
    parameter int                       CH_NUM     = 6,
    parameter int                       CNT_W      = 12,
    parameter logic [CH_NUM*CNT_W-1:0]  CH_TMO     = {CH_NUM{CNT_W'(TMO_4US)}},
    parameter int                       SETTLE_CYC = 16,
    parameter int                       ADC_DW     = 10,
    parameter int                       ADC_CH     = CH_NUM - 1,
    parameter logic [ADC_DW-1:0]        ADC_DN_TH  = ADC_DW'('h1F8),
    parameter logic [ADC_DW-1:0]        ADC_UP_TH  = ADC_DW'('h207)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [CH_NUM-1:0] i_ch_en,
    input  logic [CH_NUM-1:0] i_detect,
    input  logic [ADC_DW-1:0] i_adc_data1,
    input  logic [ADC_DW-1:0] i_adc_data2,
    output logic [CH_NUM-1:0] o_bist_req,
    output logic              o_busy,
    output logic              o_done,
    output logic [CH_NUM-1:0] o_pass,
    output logic [CH_NUM-1:0] o_fail,
    output logic              o_fail_any
);

    localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

    state_t            state_q, state_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [IDX_W-1:0]  cur_q, cur_n;
    logic [CH_NUM-1:0] en_q, en_n;
    logic [CH_NUM-1:0] req_q, req_n;
    logic [CH_NUM-1:0] pass_q, pass_n;
    logic [CH_NUM-1:0] fail_q, fail_n;
    logic              done_q, done_n;
    logic              busy_q, busy_n;
    logic              fail_any_q;

    logic [CH_NUM-1:0] det;
    logic [CH_NUM-1:0] cur_oh;
    logic [CH_NUM-1:0] sel_oh;
    logic [CNT_W-1:0]  tmo_cur;
    logic              det_cur;
    logic              tmo_hit;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_sel;

`ifdef HV_ABIST_ADC_WIN_EN
    logic adc_ok;
    logic det_unused;

    always_comb begin
        adc_ok = (i_adc_data1 >= ADC_DN_TH) && (i_adc_data1 <= ADC_UP_TH) &&
                 (i_adc_data2 >= ADC_DN_TH) && (i_adc_data2 <= ADC_UP_TH);
        det         = i_detect;
        det[ADC_CH] = adc_ok;
    end
    assign det_unused = i_detect[ADC_CH];
`else
    logic adc_unused;

    assign det        = i_detect;
    assign adc_unused = ^{i_adc_data1, i_adc_data2};
`endif

    // One encoder serves both first pick (from raw i_ch_en in IDLE) and next pick.
    hv_abist_pick #(
        .N  (CH_NUM),
        .IW (IDX_W)
    ) u_pick (
        .mask      ((state_q == S_IDLE) ? i_ch_en : en_q),
        .idx       (cur_q),
        .from_zero (state_q == S_IDLE),
        .found     (pick_found),
        .sel       (pick_sel)
    );

    assign cur_oh  = CH_NUM'(1) << cur_q;
    assign sel_oh  = CH_NUM'(1) << pick_sel;
    assign tmo_cur = CNT_W'(tmo_slice(TMO_VEC_W'(CH_TMO), 32'(cur_q), CNT_W));
    assign det_cur = |(det & cur_oh);
    assign tmo_hit = (tmo_cur == '0) || (cnt_q == tmo_cur - CNT_W'(1));

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        cur_n   = cur_q;
        en_n    = en_q;
        req_n   = req_q;
        pass_n  = pass_q;
        fail_n  = fail_q;

        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_abort) begin
                    en_n   = i_ch_en;
                    pass_n = '0;
                    fail_n = '0;
                    cnt_n  = '0;
                    if (pick_found) begin
                        cur_n   = pick_sel;
                        req_n   = sel_oh;
                        state_n = S_WAIT;
                    end else begin
                        state_n = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (det_cur) begin
                    pass_n  = pass_q | cur_oh;
                    req_n   = '0;
                    cnt_n   = '0;
                    state_n = S_SETTLE;
                end else if (tmo_hit) begin
                    fail_n  = fail_q | cur_oh;
                    req_n   = '0;
                    cnt_n   = '0;
                    state_n = S_SETTLE;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                    cnt_n = '0;
                    if (pick_found) begin
                        cur_n   = pick_sel;
                        req_n   = sel_oh;
                        state_n = S_WAIT;
                    end else begin
                        state_n = S_DONE;
                    end
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Abort overrides any same-cycle detect/timeout result.
        if (i_abort && (state_q != S_IDLE)) begin
            state_n = S_IDLE;
            req_n   = '0;
            cnt_n   = '0;
            pass_n  = pass_q;
            fail_n  = fail_q;
        end

        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cur_q      <= '0;
            en_q       <= '0;
            req_q      <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            fail_any_q <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            cur_q      <= cur_n;
            en_q       <= en_n;
            req_q      <= req_n;
            pass_q     <= pass_n;
            fail_q     <= fail_n;
            done_q     <= done_n;
            busy_q     <= busy_n;
            fail_any_q <= |fail_n;
        end
    end

    assign o_bist_req = req_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_pass     = pass_q;
    assign o_fail     = fail_q;
    assign o_fail_any = fail_any_q;

endmodule

// File: tb/tb_hv_abist_seq.sv
// Randomised bench for hv_abist_seq; expectations come from a per-run schedule
// model (request windows, settle gaps, done cycle) built from the sequencing rules.
module tb_hv_abist_seq;

    localparam int CH = 6;
    localparam int T  = 80;
    localparam int S  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CH-1:0] ch_en = '0;
    logic [CH-1:0] detect = '0;
    logic [9:0]    adc1 = '0;
    logic [9:0]    adc2 = '0;
    logic [CH-1:0] req;
    logic          busy;
    logic          done;
    logic [CH-1:0] pass;
    logic [CH-1:0] fail;
    logic          fail_any;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hv_abist_seq #(
        .CH_NUM     (CH),
        .CNT_W      (12),
        .CH_TMO     ({CH{12'd80}}),
        .SETTLE_CYC (S),
        .ADC_DW     (10),
        .ADC_CH     (CH - 1),
        .ADC_DN_TH  (10'h1F8),
        .ADC_UP_TH  (10'h207)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_abort     (abort),
        .i_ch_en     (ch_en),
        .i_detect    (detect),
        .i_adc_data1 (adc1),
        .i_adc_data2 (adc2),
        .o_bist_req  (req),
        .o_busy      (busy),
        .o_done      (done),
        .o_pass      (pass),
        .o_fail      (fail),
        .o_fail_any  (fail_any)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    function automatic bit in_win(input logic [9:0] v);
        return (v >= 10'h1F8) && (v <= 10'h207);
    endfunction

    // dly[ch]: cycles after request rise until the front end raises detect; -1 = never.
    task automatic run_seq(input string name, input logic [CH-1:0] en, input int dly [CH],
                           input int abort_at, input int start_at,
                           input logic [9:0] a1, input logic [9:0] a2);
        logic [CH-1:0] q_req[$];
        bit            q_busy[$];
        bit            q_done[$];
        int            last [CH];
        bit            ok [CH];
        int            age [CH];
        logic [CH-1:0] e_pass;
        logic [CH-1:0] e_fail;
        int            d;
        int            h;
        int            n;

        for (int ch = 0; ch < CH; ch++) begin
            last[ch] = 0;
            ok[ch]   = 1'b0;
            age[ch]  = 0;
            if (en[ch]) begin
                d = dly[ch];
`ifdef HV_ABIST_ADC_WIN_EN
                if (ch == CH - 1)
                    d = (in_win(a1) && in_win(a2)) ? 0 : -1;
`endif
                ok[ch] = (d >= 0) && (d < T);
                h = ok[ch] ? d + 1 : T;
                repeat (h) begin
                    q_req.push_back(CH'(1) << ch);
                    q_busy.push_back(1'b1);
                    q_done.push_back(1'b0);
                end
                last[ch] = q_req.size();
                repeat (S) begin
                    q_req.push_back('0);
                    q_busy.push_back(1'b1);
                    q_done.push_back(1'b0);
                end
            end
        end
        q_req.push_back('0); q_busy.push_back(1'b1); q_done.push_back(1'b1);
        repeat (2) begin
            q_req.push_back('0); q_busy.push_back(1'b0); q_done.push_back(1'b0);
        end

        e_pass = '0;
        e_fail = '0;
        for (int ch = 0; ch < CH; ch++) begin
            if (en[ch] && (abort_at <= 0 || last[ch] < abort_at)) begin
                if (ok[ch]) e_pass[ch] = 1'b1;
                else        e_fail[ch] = 1'b1;
            end
        end
        n = q_req.size();
        if (abort_at > 0) begin
            for (int c = abort_at; c < n; c++) begin
                q_req[c] = '0; q_busy[c] = 1'b0; q_done[c] = 1'b0;
            end
            if (abort_at + 3 < n) n = abort_at + 3;
        end

        adc1 = a1;
        adc2 = a2;
        @(negedge clk);
        start = 1'b1;
        ch_en = en;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            start = (c == start_at);
            ch_en = CH'($urandom);
            checks++;
            if ({req, busy, done} !== {q_req[c-1], q_busy[c-1], q_done[c-1]}) begin
                errors++;
                $display("FAIL %s cycle %0d: req/busy/done got %b/%b/%b expected %b/%b/%b",
                         name, c, req, busy, done, q_req[c-1], q_busy[c-1], q_done[c-1]);
            end
            for (int ch = 0; ch < CH; ch++) begin
                if (req[ch]) begin
                    detect[ch] = (dly[ch] >= 0) && (age[ch] >= dly[ch]);
                    age[ch]++;
                end else begin
                    age[ch]    = 0;
                    detect[ch] = 1'($urandom);
                end
            end
            abort = (c == abort_at);
        end
        start  = 1'b0;
        abort  = 1'b0;
        detect = '0;

        checks++;
        if (pass !== e_pass) begin
            errors++;
            $display("FAIL %s pass: got %b expected %b", name, pass, e_pass);
        end
        checks++;
        if (fail !== e_fail) begin
            errors++;
            $display("FAIL %s fail: got %b expected %b", name, fail, e_fail);
        end
        checks++;
        if (fail_any !== (|e_fail)) begin
            errors++;
            $display("FAIL %s fail_any: got %b expected %b", name, fail_any, |e_fail);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({req, busy, done, pass, fail, fail_any} !== '0) begin
            errors++;
            $display("FAIL %s: req/busy/done/pass/fail/fail_any got %b/%b/%b/%b/%b/%b expected all 0",
                     name, req, busy, done, pass, fail, fail_any);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_all_pass();
        int dly [CH] = '{3, 3, 3, 3, 3, 3};
        run_seq("all_pass", 6'b111111, dly, 0, 0, 10'h000, 10'h000);
    endtask

    task automatic test_timeout();
        int dly [CH] = '{3, 0, -1, 0, 0, 0};
        // start pulse at cycle 30 lands while busy and must be ignored
        run_seq("timeout", 6'b000101, dly, 0, 30, 10'h000, 10'h000);
    endtask

    task automatic test_empty();
        int dly [CH] = '{0, 0, 0, 0, 0, 0};
        run_seq("empty", 6'b000000, dly, 0, 0, 10'h000, 10'h000);
    endtask

    task automatic test_timeout_boundary();
        int dly [CH] = '{T - 1, T, 0, T + 5, 1, T - 1};
        run_seq("tmo_boundary", 6'b111011, dly, 0, 0, 10'h000, 10'h000);
    endtask

    task automatic test_adc();
        int dly [CH] = '{0, 0, 0, 0, 0, -1};
`ifdef HV_ABIST_ADC_WIN_EN
        run_seq("adc_in_window", 6'b100000, dly, 0, 0, 10'h1F8, 10'h207);
        dly[CH-1] = 0;
        run_seq("adc_out_window", 6'b100000, dly, 0, 0, 10'h1F8, 10'h208);
`else
        run_seq("adc_ch_detect_fail", 6'b100000, dly, 0, 0, 10'h1F8, 10'h207);
        dly[CH-1] = 2;
        run_seq("adc_ch_detect_pass", 6'b100000, dly, 0, 0, 10'h3FF, 10'h000);
`endif
    endtask

    task automatic test_abort();
        int dly [CH] = '{2, 2, 2, 2, 2, 2};
        // ch3 request occupies cycles 58..60; abort sampled at the end of cycle 59
        run_seq("abort_ch3", 6'b111111, dly, 59, 0, 10'h000, 10'h000);
    endtask

    task automatic test_random();
        int            dly [CH];
        int            pick;
        logic [CH-1:0] en;
        for (int r = 0; r < 6; r++) begin
            en = CH'($urandom);
            for (int ch = 0; ch < CH; ch++) begin
                pick = int'($urandom_range(0, 6));
                case (pick)
                    0: dly[ch] = -1;
                    1: dly[ch] = 0;
                    2: dly[ch] = T - 1;
                    3: dly[ch] = T;
                    default: dly[ch] = int'($urandom_range(1, 100));
                endcase
            end
            run_seq($sformatf("random_%0d", r), en, dly, 0, 0,
                    10'($urandom), 10'($urandom));
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start = 1'b1;
        ch_en = 6'b111111;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req, busy} !== {6'b000001, 1'b1}) begin
            errors++;
            $display("FAIL mid_wait: req/busy got %b/%b expected 000001/1", req, busy);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_timeout();
        test_empty();
        test_timeout_boundary();
        test_adc();
        test_abort();
        test_random();
        test_reset_mid_run();
        test_empty();
        test_all_pass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
